// File: rtl/mux1hot_rr_arbiter_pkg.sv
// Shared constants, state type and rotate-pick helpers for the
// round-robin one-hot mux arbiter.
package mux1hot_pkg;

    localparam int N_REQ = 8;
    localparam int PTR_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set bit scanning ptr, ptr+1, ... with 3-bit wrap.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [N_REQ-1:0] res;
        logic [PTR_W-1:0] idx;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + PTR_W'(k);
            if (!found && req[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (oh[k]) idx = idx | PTR_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux1hot_rr_arbiter_if.sv
// Requester/consumer bundle of the arbiter; slave is the arbiter side,
// master is the environment driving requests and consuming beats.
interface mux1hot_rr_arbiter_if
    import mux1hot_pkg::*;
#(
    parameter int W = 8
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   last;
    logic [N_REQ*W-1:0] in_data;
    logic [W-1:0]       dflt;
    logic               out_ready;
    logic [W-1:0]       out;
    logic               out_valid;
    logic               out_last;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic               timeout;

    modport master (
        output req, last, in_data, dflt, out_ready,
        input  out, out_valid, out_last, gnt, ack, timeout
    );

    modport slave (
        input  req, last, in_data, dflt, out_ready,
        output out, out_valid, out_last, gnt, ack, timeout
    );
endinterface

// File: rtl/mux1hot_rr_arbiter_mux.sv
// 8-way one-hot mux; an all-zero select routes dflt to the output.
module onehot_mux8
    import mux1hot_pkg::*;
#(
    parameter int W = 8
)(
    input  logic [N_REQ-1:0]   sel,
    input  logic [N_REQ*W-1:0] in_data,
    input  logic [W-1:0]       dflt,
    output logic [W-1:0]       out
);
    always_comb begin
        out = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel[i]) out = out | in_data[i*W +: W];
        end
        if (sel == '0) out = dflt;
    end
endmodule

// File: rtl/mux1hot_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: one-hot of the first request at or
// after ptr, plus an any-request flag.
module rr_pick8
    import mux1hot_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic             any
);
    assign onehot = rr_pick(req, ptr);
    assign any    = |req;
endmodule

// File: rtl/mux1hot_rr_arbiter.sv
// Round-robin owner of a shared one-hot mux: registered grant held for a
// multi-beat transfer, released on last beat, abandonment or hold timeout.
module mux1hot_rr_arbiter
    import mux1hot_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
)(
    input  logic                 clk,
    input  logic                 rst_n,
    mux1hot_rr_arbiter_if.slave  bus
);
    localparam int               HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [PTR_W-1:0]  owner;
    logic              own_req, own_last;
    logic              valid, xfer, hold_expired, release_now;
    logic [N_REQ-1:0]  pick_req, pick_oh;
    logic [PTR_W-1:0]  pick_ptr;
    logic              pick_any;

    assign owner    = onehot_idx(gnt_q);
    assign own_req  = |(bus.req & gnt_q);
    assign own_last = |(bus.last & gnt_q);

    // One picker serves both IDLE arbitration and hand-over on release;
    // during GRANT the owner is masked so it cannot be regranted directly.
    assign pick_req = (state_q == GRANT) ? (bus.req & ~gnt_q) : bus.req;
    assign pick_ptr = (state_q == GRANT) ? (owner + PTR_W'(1)) : ptr_q;

    rr_pick8 u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .any    (pick_any)
    );

    onehot_mux8 #(.W(W)) u_mux (
        .sel     (gnt_q),
        .in_data (bus.in_data),
        .dflt    (bus.dflt),
        .out     (bus.out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_oh;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d  = owner + PTR_W'(1);
                    hold_d = '0;
                    if (pick_any) begin
                        gnt_d = pick_oh;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    hold_d = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        valid        = 1'b0;
        hold_expired = 1'b0;
        release_now  = 1'b0;
        if (state_q == GRANT) valid = own_req;
        xfer = valid & bus.out_ready;
        if (state_q == GRANT) begin
            hold_expired = (hold_q == HOLD_LAST) && !xfer;
            release_now  = (xfer && own_last) || !own_req || hold_expired;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.out_valid = valid;
    assign bus.out_last  = valid & own_last;
    assign bus.ack       = gnt_q & {N_REQ{xfer}};
    assign bus.timeout   = hold_expired;

endmodule

// File: tb/tb_mux1hot_rr_arbiter.sv
// Bench for mux1hot_rr_arbiter: directed vector table, hand sequences for
// timeout and async reset, and random traffic against a reference model.
module tb_mux1hot_rr_arbiter;

    localparam int W        = 8;
    localparam int MAX_HOLD = 16;

    logic clk;
    logic rst_n;

    mux1hot_rr_arbiter_if #(.W(W)) bus ();

    mux1hot_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: owner index (-1 idle), pointer, stall count
    int m_owner;
    int m_ptr;
    int m_hold;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] last;
        logic       rdy;
        logic [7:0] gnt;
        logic [7:0] ack;
        logic       tmo;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int from);
        for (int k = 0; k < 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    function automatic logic m_valid();
        return (m_owner >= 0) && bus.req[m_owner];
    endfunction

    function automatic logic m_xfer();
        return m_valid() && bus.out_ready;
    endfunction

    function automatic logic m_tmo();
        return (m_owner >= 0) && (m_hold == MAX_HOLD - 1) && !m_xfer();
    endfunction

    task automatic model_update();
        logic [7:0] rest;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (bus.req != 8'h00) begin
                m_owner = pick(bus.req, m_ptr);
                m_hold  = 0;
            end
        end else if ((m_xfer() && bus.last[m_owner]) || !bus.req[m_owner] || m_tmo()) begin
            rest    = bus.req & ~(8'h01 << m_owner);
            m_ptr   = (m_owner + 1) % 8;
            m_owner = pick(rest, m_ptr);
            m_hold  = 0;
        end else if (m_xfer()) begin
            m_hold = 0;
        end else if (m_hold < MAX_HOLD - 1) begin
            m_hold = m_hold + 1;
        end
    endtask

    task automatic check_all();
        logic [7:0] e_gnt;
        logic [7:0] e_out;
        e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        e_out = (m_owner >= 0) ? bus.in_data[m_owner*W +: W] : bus.dflt;
        chk("gnt",       bus.gnt, e_gnt);
        chk("out",       bus.out, e_out);
        chk("out_valid", bus.out_valid, m_valid());
        chk("out_last",  bus.out_last, m_valid() && bus.last[m_owner]);
        chk("ack",       bus.ack, m_xfer() ? e_gnt : 8'h00);
        chk("timeout",   bus.timeout, m_tmo());
        chk("gnt_onehot0", $onehot0(bus.gnt), 1'b1);
    endtask

    task automatic apply(input logic [7:0] r, input logic [7:0] l, input logic rd);
        bus.req       = r;
        bus.last      = l;
        bus.out_ready = rd;
        bus.in_data   = {$urandom, $urandom};
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        check_all();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        cyc_begin();
        cyc_end();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h01, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{8'h01, 8'h00, 1'b1, 8'h01, 8'h01, 1'b0};
        tbl[2]  = '{8'h01, 8'h00, 1'b1, 8'h01, 8'h01, 1'b0};
        tbl[3]  = '{8'h01, 8'h01, 1'b1, 8'h01, 8'h01, 1'b0};
        tbl[4]  = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{8'hFF, 8'hFF, 1'b1, 8'h02, 8'h02, 1'b0};
        tbl[7]  = '{8'hFF, 8'hFF, 1'b1, 8'h04, 8'h04, 1'b0};
        tbl[8]  = '{8'hFF, 8'hFF, 1'b1, 8'h08, 8'h08, 1'b0};
        tbl[9]  = '{8'hFF, 8'hFF, 1'b1, 8'h10, 8'h10, 1'b0};
        tbl[10] = '{8'hFF, 8'hFF, 1'b1, 8'h20, 8'h20, 1'b0};
        tbl[11] = '{8'hFF, 8'hFF, 1'b1, 8'h40, 8'h40, 1'b0};
        tbl[12] = '{8'hFF, 8'hFF, 1'b1, 8'h80, 8'h80, 1'b0};
        tbl[13] = '{8'hFF, 8'hFF, 1'b1, 8'h01, 8'h01, 1'b0};
        tbl[14] = '{8'h00, 8'h00, 1'b1, 8'h02, 8'h00, 1'b0};
        tbl[15] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[16] = '{8'h81, 8'h81, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[17] = '{8'h81, 8'h81, 1'b1, 8'h80, 8'h80, 1'b0};
        tbl[18] = '{8'h81, 8'h81, 1'b1, 8'h01, 8'h01, 1'b0};
        tbl[19] = '{8'h00, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0};
        tbl[20] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};

        rst_n    = 1'b0;
        bus.dflt = 8'hA5;
        apply(8'h00, 8'h00, 1'b0);
        model_reset();
        #1;
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc_begin();
            chk("idle_out_dflt", bus.out, 8'hA5);
            chk("idle_gnt", bus.gnt, 8'h00);
            cyc_end();
        end

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].req, tbl[i].last, tbl[i].rdy);
            cyc_begin();
            chk($sformatf("tbl%0d_gnt", i), bus.gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_ack", i), bus.ack, tbl[i].ack);
            chk($sformatf("tbl%0d_tmo", i), bus.timeout, tbl[i].tmo);
            cyc_end();
        end

        // owner 2 stalls; 3 waits and takes over right after the timeout
        apply(8'h0C, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < MAX_HOLD; i++) begin
            apply(8'h0C, 8'h00, 1'b0);
            cyc_begin();
            chk("tmo_hold_gnt", bus.gnt, 8'h04);
            chk("tmo_pulse", bus.timeout, (i == MAX_HOLD - 1));
            cyc_end();
        end
        apply(8'h0C, 8'h00, 1'b0);
        cyc_begin();
        chk("tmo_next_gnt", bus.gnt, 8'h08);
        chk("tmo_after", bus.timeout, 1'b0);
        cyc_end();
        apply(8'h00, 8'h00, 1'b1);
        tick();
        tick();

        // async reset in the middle of a grant
        apply(8'h04, 8'h00, 1'b0);
        tick();
        cyc_begin();
        chk("pre_rst_gnt", bus.gnt, 8'h04);
        cyc_end();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_gnt", bus.gnt, 8'h00);
        chk("rst_async_out", bus.out, 8'hA5);
        chk("rst_async_valid", bus.out_valid, 1'b0);
        chk("rst_async_ack", bus.ack, 8'h00);
        model_reset();
        cyc_end();
        tick();
        rst_n = 1'b1;
        apply(8'hFF, 8'hFF, 1'b1);
        tick();
        cyc_begin();
        chk("post_rst_gnt", bus.gnt, 8'h01);
        cyc_end();
        apply(8'h00, 8'h00, 1'b1);
        tick();
        tick();

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            logic       rd;
            if ((n % 200) < 40) begin
                r  = 8'hFF;
                rd = 1'b0;
            end else begin
                r  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                rd = ($urandom_range(0, 3) != 0);
            end
            bus.dflt = 8'($urandom);
            apply(r, 8'($urandom) & 8'($urandom), rd);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
